// File: rtl/arb_pkg.sv
// Helpers shared by the arbiter family: constant-width log2 and one-hot decode.
package arb_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index of the set bit; 0 for an all-zero vector. Vectors up to 64 bits.
  function automatic int onehot_to_idx(input logic [63:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Round-robin pick: first requester after ptr, wrapping mod N, found by
// scanning a doubled request vector with the bits at or below ptr masked off.
module rr_pick_n import arb_pkg::*; #(
  parameter int N   = 6,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id
);

  logic [2*N-1:0] masked;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_mask
      if (gi < N) begin : g_lo
        assign masked[gi] = req[gi] & (gi > int'(ptr));
      end else begin : g_hi
        assign masked[gi] = req[gi-N];
      end
    end
  endgenerate

  always_comb begin
    logic found;
    found   = 1'b0;
    pick    = '0;
    pick_id = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && masked[i]) begin
        found         = 1'b1;
        pick[i % N]   = 1'b1;
        pick_id       = IDW'(i % N);
      end
    end
  end

endmodule

// File: rtl/arb_rr_hold_n.sv
// N-way round-robin arbiter with grant hold, bounded hold length and a
// priority pointer that survives idle cycles.
module arb_rr_hold_n import arb_pkg::*; #(
  parameter int N        = 6,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = clog2(N)
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   hold,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   last_gnt,
  output logic           hold_expired
);

  localparam int HCW = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] MAX_HOLD_W = HCW'(MAX_HOLD);
  localparam logic [IDW-1:0] PTR_RST    = IDW'(N - 1);

  logic [IDW-1:0] ptr_reg;
  logic [HCW-1:0] hold_cnt_reg;
  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;
  logic           held;
  logic           limit_ok;
  logic           hold_ok;

  rr_pick_n #(.N(N), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // last_gnt is one-hot or zero, so this is the holder asking to keep it.
  assign held     = |(last_gnt & hold);
  assign limit_ok = (MAX_HOLD == 0) || (hold_cnt_reg < MAX_HOLD_W);
  assign hold_ok  = held && limit_ok;

  assign hold_expired = held && (MAX_HOLD != 0) && (hold_cnt_reg == MAX_HOLD_W);
  assign gnt          = hold_ok ? last_gnt : pick;
  assign gnt_valid    = |gnt;
  assign gnt_id       = hold_ok ? IDW'(onehot_to_idx(64'(last_gnt))) : pick_id;

  always_ff @(posedge CLK) begin
    if (rst) begin
      last_gnt     <= '0;
      ptr_reg      <= PTR_RST;
      hold_cnt_reg <= '0;
    end else begin
      last_gnt <= gnt;
      if (hold_ok) begin
        if (MAX_HOLD != 0 && hold_cnt_reg < MAX_HOLD_W)
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end else begin
        hold_cnt_reg <= '0;
        if (|pick) ptr_reg <= pick_id;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_hold_n.sv
// Directed bench for arb_rr_hold_n: N=6 with MAX_HOLD=4, plus a MAX_HOLD=0 copy.
module tb_arb_rr_hold_n;

  localparam int N   = 6;
  localparam int IDW = 3;

  logic           CLK = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   hold;

  logic [N-1:0]   gnt,  gnt0;
  logic           gnt_valid, gnt_valid0;
  logic [IDW-1:0] gnt_id, gnt_id0;
  logic [N-1:0]   last_gnt, last_gnt0;
  logic           hold_expired, hold_expired0;

  int n_cmp = 0;
  int n_err = 0;

  arb_rr_hold_n #(.N(N), .MAX_HOLD(4)) dut (
    .CLK(CLK), .rst(rst), .req(req), .hold(hold),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .last_gnt(last_gnt), .hold_expired(hold_expired)
  );

  arb_rr_hold_n #(.N(N), .MAX_HOLD(0)) dut0 (
    .CLK(CLK), .rst(rst), .req(req), .hold(hold),
    .gnt(gnt0), .gnt_valid(gnt_valid0), .gnt_id(gnt_id0),
    .last_gnt(last_gnt0), .hold_expired(hold_expired0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Waits for the negedge, then checks the MAX_HOLD=4 outputs; id<0 means no grant.
  task automatic expect_g(input string tag, input int id, input logic expd);
    logic [N-1:0] eg;
    @(negedge CLK);
    eg = (id < 0) ? '0 : (N'(1) << id);
    chk({tag, ".gnt"},       32'(gnt),          32'(eg));
    chk({tag, ".valid"},     32'(gnt_valid),    32'(id >= 0));
    chk({tag, ".id"},        32'(gnt_id),       (id < 0) ? 32'd0 : 32'(id));
    chk({tag, ".expired"},   32'(hold_expired), 32'(expd));
    $display("step %s: req=%b hold=%b gnt=%b id=%0d exp=%b", tag, req, hold, gnt, gnt_id, hold_expired);
  endtask

  initial begin
    int seq1[7] = '{0, 1, 2, 3, 4, 5, 0};
    int ids3[10] = '{2, 2, 2, 2, 3, 4, 5, 0, 1, 2};
    int exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [N-1:0] prev;

    // Reset state
    rst = 1'b1; req = '0; hold = '0;
    tick;
    expect_g("rst", -1, 1'b0);
    chk("rst.last", 32'(last_gnt), 32'd0);
    tick;
    rst = 1'b0;

    // Full request round-robin rotation
    req = 6'b111111;
    prev = '0;
    for (int c = 0; c < 7; c++) begin
      expect_g($sformatf("rr%0d", c), seq1[c], 1'b0);
      chk($sformatf("rr%0d.last", c), 32'(last_gnt), 32'(prev));
      prev = N'(1) << seq1[c];
      tick;
    end

    // Idle retention: winner 3, idle, then the next full request goes to 4
    req = 6'b001000;
    expect_g("idle.w3", 3, 1'b0);
    tick;
    req = '0;
    for (int c = 0; c < 5; c++) begin
      expect_g($sformatf("idle%0d", c), -1, 1'b0);
      tick;
    end
    req = 6'b111111;
    expect_g("idle.after", 4, 1'b0);
    tick;

    // Hold limit: requester 2 holds while everyone requests
    req = 6'b000100; hold = '0;
    expect_g("hl.w2", 2, 1'b0);
    tick;
    req = 6'b111111; hold = 6'b000100;
    for (int c = 0; c < 10; c++) begin
      expect_g($sformatf("hl%0d", c), ids3[c], exp3[c] != 0);
      chk($sformatf("hl0_%0d.gnt", c), 32'(gnt0), 32'(6'b000100));
      chk($sformatf("hl0_%0d.expired", c), 32'(hold_expired0), 32'd0);
      tick;
    end

    rst = 1'b1; req = '0; hold = '0;
    tick;
    rst = 1'b0;

    // Hold without request, expiry re-grant, then expiry with no request
    req = 6'b100000;
    expect_g("hn.w5", 5, 1'b0);
    tick;
    req = '0; hold = 6'b100000;
    for (int c = 0; c < 4; c++) begin
      expect_g($sformatf("hn%0d", c), 5, 1'b0);
      tick;
    end
    req = 6'b100000;
    expect_g("hn.regrant", 5, 1'b1);
    tick;
    req = '0;
    for (int c = 0; c < 4; c++) begin
      expect_g($sformatf("hn2_%0d", c), 5, 1'b0);
      tick;
    end
    expect_g("hn.drop", -1, 1'b1);
    tick;

    // Reset in the middle of a hold by requester 1
    req = 6'b000010; hold = '0;
    expect_g("rm.w1", 1, 1'b0);
    tick;
    req = 6'b111111; hold = 6'b000010;
    expect_g("rm.hold", 1, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    expect_g("rm.after", 0, 1'b0);
    chk("rm.last", 32'(last_gnt), 32'd0);
    tick;

    // Sparse requests wrapping past N-1
    hold = '0; req = 6'b010000;
    expect_g("sp.w4", 4, 1'b0);
    tick;
    req = 6'b000011;
    expect_g("sp.wrap", 0, 1'b0);
    tick;
    expect_g("sp.next", 1, 1'b0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
